// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: payload, control and valid with flush/hold/squash resolution.
// Build with PIPE_STAGE_PERF_EN defined to add saturating stall/squash/flush counters.
module pipe_stage_reg #(
  parameter int unsigned                 DATA_W         = 64,
  parameter int unsigned                 CTRL_W         = 8,
  parameter logic [CTRL_W-1:0]           CTRL_IDLE      = 8'h0F,
  parameter logic [CTRL_W-1:0]           CTRL_KILL_MASK = 8'h1F,
  parameter int unsigned                 N_STALL        = 2,
  parameter logic [N_STALL-1:0]          SQUASH_MASK    = 2'b01,
  parameter int unsigned                 CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_STALL-1:0] stall_i,
  input  logic               flush_i,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CTRL_W-1:0]  in_ctrl,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic               held_o,
  input  logic               clr_perf_i,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   squash_cnt_o,
  output logic [CNT_W-1:0]   flush_cnt_o
);

  // Valid semantics: out_valid marks out_data/out_ctrl as a live instruction; there is
  // no ready, so a downstream stage that cannot accept one must assert a stall source.
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_SQUASH = 2'd1,
    ACT_HOLD   = 2'd2,
    ACT_FLUSH  = 2'd3
  } action_t;

  logic    any_stall;
  logic    squash;
  logic    hold;
  action_t action;

  assign any_stall = |stall_i;
  assign squash    = any_stall && ((stall_i & ~SQUASH_MASK) == '0);
  assign hold      = any_stall && !squash;

  always_comb begin
    action = ACT_LOAD;
    if (flush_i)     action = ACT_FLUSH;
    else if (hold)   action = ACT_HOLD;
    else if (squash) action = ACT_SQUASH;
  end

  // Squash only idles the side-effect bits so a held memory access is not re-issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= CTRL_IDLE;
      held_o    <= 1'b0;
    end else begin
      case (action)
        ACT_FLUSH: begin
          out_valid <= 1'b0;
          out_ctrl  <= CTRL_IDLE;
          held_o    <= 1'b0;
        end
        ACT_HOLD: begin
          held_o <= 1'b1;
        end
        ACT_SQUASH: begin
          out_ctrl <= (out_ctrl & ~CTRL_KILL_MASK) | (CTRL_IDLE & CTRL_KILL_MASK);
          held_o   <= 1'b1;
        end
        default: begin
          out_valid <= in_valid;
          out_data  <= in_data;
          out_ctrl  <= in_valid ? in_ctrl : CTRL_IDLE;
          held_o    <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] squash_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Counters stick at all-ones; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      squash_cnt <= '0;
      flush_cnt  <= '0;
    end else if (clr_perf_i) begin
      stall_cnt  <= '0;
      squash_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (any_stall && !flush_i && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_ONE;
      if ((action == ACT_SQUASH) && (squash_cnt != '1))
        squash_cnt <= squash_cnt + CNT_ONE;
      if ((action == ACT_FLUSH) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

  assign stall_cnt_o  = stall_cnt;
  assign squash_cnt_o = squash_cnt;
  assign flush_cnt_o  = flush_cnt;
`else
  logic unused_clr_perf;
  assign unused_clr_perf = clr_perf_i;

  assign stall_cnt_o  = '0;
  assign squash_cnt_o = '0;
  assign flush_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed test-plan cases, then random stimulus
// compared every cycle against a behavioural model of the stage.
module tb_pipe_stage_reg;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 8;
  localparam int N_STALL = 2;
  localparam int CNT_W = 4;
  localparam logic [7:0] IDLE = 8'h0F;
  localparam logic [7:0] KILL = 8'h1F;
  localparam logic [1:0] SQMASK = 2'b01;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_STALL-1:0] stall_i;
  logic               flush_i;
  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic [CTRL_W-1:0]  in_ctrl;
  logic               out_valid;
  logic [DATA_W-1:0]  out_data;
  logic [CTRL_W-1:0]  out_ctrl;
  logic               held_o;
  logic               clr_perf_i;
  logic [CNT_W-1:0]   stall_cnt_o;
  logic [CNT_W-1:0]   squash_cnt_o;
  logic [CNT_W-1:0]   flush_cnt_o;

  pipe_stage_reg #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_data(out_data), .out_ctrl(out_ctrl),
    .held_o(held_o), .clr_perf_i(clr_perf_i),
    .stall_cnt_o(stall_cnt_o), .squash_cnt_o(squash_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [CTRL_W-1:0] m_ctrl;
  logic              m_held;
  int unsigned       m_stall_cnt, m_squash_cnt, m_flush_cnt;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int unsigned sat_inc(input int unsigned v);
    int unsigned max_v = (1 << CNT_W) - 1;
    return (v >= max_v) ? max_v : v + 1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_ctrl = IDLE; m_held = 1'b0;
    m_stall_cnt = 0; m_squash_cnt = 0; m_flush_cnt = 0;
  endtask

  // One clock edge worth of stage behaviour, from the current inputs.
  task automatic model_edge();
    bit any, only_squashers, is_squash;
    if (rst) begin
      model_reset();
      return;
    end
    any = (stall_i != 0);
    only_squashers = ((stall_i & ~SQMASK) == 0);
    is_squash = any && only_squashers && !flush_i;
    if (clr_perf_i) begin
      m_stall_cnt = 0; m_squash_cnt = 0; m_flush_cnt = 0;
    end else begin
      if (any && !flush_i) m_stall_cnt = sat_inc(m_stall_cnt);
      if (is_squash) m_squash_cnt = sat_inc(m_squash_cnt);
      if (flush_i) m_flush_cnt = sat_inc(m_flush_cnt);
    end
    if (flush_i) begin
      m_valid = 1'b0; m_ctrl = IDLE; m_held = 1'b0;
    end else if (any && !only_squashers) begin
      m_held = 1'b1;
    end else if (any) begin
      m_ctrl = (m_ctrl & ~KILL) | (IDLE & KILL);
      m_held = 1'b1;
    end else begin
      m_valid = in_valid;
      m_data = in_data;
      m_ctrl = in_valid ? in_ctrl : IDLE;
      m_held = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("out_data", out_data, m_data);
    check("out_ctrl", 64'(out_ctrl), 64'(m_ctrl));
    check("held_o", 64'(held_o), 64'(m_held));
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cnt", 64'(stall_cnt_o), 64'(m_stall_cnt));
    check("squash_cnt", 64'(squash_cnt_o), 64'(m_squash_cnt));
    check("flush_cnt", 64'(flush_cnt_o), 64'(m_flush_cnt));
`else
    check("cnt_tied_zero", 64'({stall_cnt_o, squash_cnt_o, flush_cnt_o}), 64'd0);
`endif
  endtask

  // Inputs change only at negedge; the DUT and model both see them at the next posedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic [1:0] st, input logic fl, input logic v,
                       input logic [63:0] d, input logic [7:0] c, input logic clr);
    stall_i = st; flush_i = fl; in_valid = v; in_data = d; in_ctrl = c; clr_perf_i = clr;
  endtask

  task automatic drive_random();
    int r = $urandom_range(0, 9);
    stall_i = (r < 5) ? 2'b00 : 2'($urandom_range(0, 3));
    flush_i = ($urandom_range(0, 11) == 0);
    in_valid = ($urandom_range(0, 3) != 0);
    in_data = {$urandom, $urandom};
    in_ctrl = 8'($urandom);
    clr_perf_i = ($urandom_range(0, 29) == 0);
  endtask

  initial begin
    rst = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 64'd0, 8'd0, 1'b0);
    model_reset();
    repeat (2) step();
    check("reset_ctrl_idle", 64'(out_ctrl), 64'h0F);
    check("reset_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;

    // 1. plain load
    drive(2'b00, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_1234, 8'hE5, 1'b0);
    step();
    check("load_data", out_data, 64'hDEAD_BEEF_0000_1234);
    check("load_ctrl", 64'(out_ctrl), 64'hE5);
    check("load_valid", 64'(out_valid), 64'd1);
    check("load_held", 64'(held_o), 64'd0);

    // 2. IM-only squash with changing inputs, then release
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 1'b0, 1'b1, {$urandom, $urandom}, 8'($urandom), 1'b0);
      step();
      check("squash_ctrl", 64'(out_ctrl), 64'hEF);
      check("squash_data", out_data, 64'hDEAD_BEEF_0000_1234);
      check("squash_held", 64'(held_o), 64'd1);
    end
    drive(2'b00, 1'b0, 1'b1, 64'h1111_2222_3333_4444, 8'hA0, 1'b0);
    step();
    check("release_data", out_data, 64'h1111_2222_3333_4444);
    check("release_ctrl", 64'(out_ctrl), 64'hA0);
    check("release_held", 64'(held_o), 64'd0);

    // 3. hard hold with both stalls, then DM only
    drive(2'b00, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_1234, 8'hE5, 1'b0);
    step();
    drive(2'b11, 1'b0, 1'b1, 64'h5555, 8'h00, 1'b0);
    step();
    check("hold11_ctrl", 64'(out_ctrl), 64'hE5);
    check("hold11_held", 64'(held_o), 64'd1);
    drive(2'b10, 1'b0, 1'b0, 64'h6666, 8'h00, 1'b0);
    step();
    check("hold10_ctrl", 64'(out_ctrl), 64'hE5);
    check("hold10_data", out_data, 64'hDEAD_BEEF_0000_1234);

    // 4. flush beats a stall
    drive(2'b10, 1'b1, 1'b1, 64'h7777, 8'hFF, 1'b0);
    step();
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ctrl", 64'(out_ctrl), 64'h0F);
    check("flush_data", out_data, 64'hDEAD_BEEF_0000_1234);
    check("flush_held", 64'(held_o), 64'd0);

    // 5. asynchronous reset between edges while stalled
    drive(2'b00, 1'b0, 1'b1, 64'hCAFE_F00D_0000_0001, 8'hE5, 1'b0);
    step();
    drive(2'b11, 1'b0, 1'b1, 64'h8888, 8'h11, 1'b0);
    step();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_data", out_data, 64'd0);
    check("arst_ctrl", 64'(out_ctrl), 64'h0F);
    check("arst_held", 64'(held_o), 64'd0);
    check("arst_cnt", 64'(stall_cnt_o), 64'd0);
    @(negedge clk);
    compare_all();
    rst = 1'b0;
    drive(2'b00, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 8'h3C, 1'b0);
    step();
    check("post_rst_data", out_data, 64'h0123_4567_89AB_CDEF);
    check("post_rst_ctrl", 64'(out_ctrl), 64'h3C);

    // 6. counter saturation and clear-with-stall
    drive(2'b10, 1'b0, 1'b1, 64'h9, 8'h1, 1'b0);
    for (int i = 0; i < 20; i++) step();
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cnt_sat", 64'(stall_cnt_o), 64'hF);
`else
    check("stall_cnt_off", 64'(stall_cnt_o), 64'h0);
`endif
    drive(2'b10, 1'b0, 1'b1, 64'h9, 8'h1, 1'b1);
    step();
    check("clr_with_stall", 64'(stall_cnt_o), 64'h0);
    clr_perf_i = 1'b0;

    // random phase
    for (int i = 0; i < 500; i++) begin
      drive_random();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
